// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// Data has priority; a streak counter forces a fetch grant to avoid starvation.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 64,
    parameter logic [31:0] ERR_DATA        = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [7:0]  d_mask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_mask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_sticky
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  mem_mask_q, mem_mask_d;
    logic        if_gnt_q, if_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_gnt_q, d_gnt_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;
    logic        err_sticky_q, err_sticky_d;
    logic        fetch_wins;
    logic        resp;
    logic        resp_err;
    logic [31:0] resp_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        streak_d     = streak_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        err_sticky_d = err_sticky_q;
        if_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = 32'h0;
        d_gnt_d      = 1'b0;
        d_rvalid_d   = 1'b0;
        d_rdata_d    = 32'h0;
        d_err_d      = 1'b0;
        fetch_wins   = if_req && (!d_req || streak_q == STREAK_MAX);
        resp         = 1'b0;
        resp_err     = 1'b0;
        resp_data    = 32'h0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    if (fetch_wins) begin
                        owner_d     = OWN_IF;
                        if_gnt_d    = 1'b1;
                        streak_d    = 4'd0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'h0;
                        mem_mask_d  = 8'h0;
                    end else begin
                        owner_d     = OWN_D;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_mask_d  = d_mask;
                        if (!if_req)
                            streak_d = 4'd0;
                        else if (streak_q != 4'hF)
                            streak_d = streak_q + 4'd1;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_D && mem_we_q) begin
                        d_rvalid_d = 1'b1;
                        state_d    = IDLE;
                        owner_d    = OWN_NONE;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    resp_data = mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    resp         = 1'b1;
                    resp_err     = 1'b1;
                    resp_data    = ERR_DATA;
                    err_sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // Route the read response to whoever owns the transaction.
        if (resp) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
            d_err_d = resp_err;
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = resp_data;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            streak_q     <= 4'd0;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_mask_q   <= 8'h0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'h0;
            d_gnt_q      <= 1'b0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'h0;
            d_err_q      <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            streak_q     <= streak_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            if_gnt_q     <= if_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_gnt_q      <= d_gnt_d;
            d_rvalid_q   <= d_rvalid_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign if_gnt     = if_gnt_q;
    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign d_gnt      = d_gnt_q;
    assign d_rvalid   = d_rvalid_q;
    assign d_rdata    = d_rdata_q;
    assign d_err      = d_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_mask   = mem_mask_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation guard,
// read timeout, rvalid/timeout collision and asynchronous reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [7:0]  d_mask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_mask(d_mask), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_sticky(err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctl();
        return {24'h0, mem_req, mem_we, if_gnt, if_rvalid,
                d_gnt, d_rvalid, d_err, err_sticky};
    endfunction

    initial begin
        int k;
        int n;
        reset = 1'b0;
        if_req = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick();
        tick();
        chk("rst_ctl", ctl(), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdata", d_rdata | if_rdata, 32'h0);
        reset = 1'b1;
        tick();

        // Fetch-only read
        if_req = 1; if_addr = 32'h100;
        tick();
        chk("f_gnt", {31'h0, if_gnt}, 32'h1);
        chk("f_dgnt", {31'h0, d_gnt}, 32'h0);
        chk("f_mreq", {31'h0, mem_req}, 32'h1);
        chk("f_addr", mem_addr, 32'h100);
        chk("f_we", {31'h0, mem_we}, 32'h0);
        if_req = 0; mem_gnt = 1;
        tick();
        chk("f_mreq_drop", {31'h0, mem_req}, 32'h0);
        mem_gnt = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 0;
        chk("f_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("f_rdata", if_rdata, 32'h12345678);
        chk("f_err", {31'h0, d_err}, 32'h0);
        chk("f_drv", {31'h0, d_rvalid}, 32'h0);
        tick();
        chk("f_rv_pulse", {31'h0, if_rvalid}, 32'h0);

        // Store with delayed mem_gnt
        d_req = 1; d_we = 1; d_addr = 32'h40;
        d_wdata = 32'hA5A5A5A5; d_mask = 8'h0F;
        tick();
        chk("s_gnt", {31'h0, d_gnt}, 32'h1);
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s_req%0d", i), {31'h0, mem_req}, 32'h1);
            chk($sformatf("s_we%0d", i), {31'h0, mem_we}, 32'h1);
            chk($sformatf("s_addr%0d", i), mem_addr, 32'h40);
            chk($sformatf("s_wd%0d", i), mem_wdata, 32'hA5A5A5A5);
            chk($sformatf("s_mask%0d", i), {24'h0, mem_mask}, 32'h0F);
            chk($sformatf("s_rv%0d", i), {31'h0, d_rvalid}, 32'h0);
            if (i == 3) mem_gnt = 1;
            tick();
        end
        mem_gnt = 0;
        chk("s_done", {31'h0, d_rvalid}, 32'h1);
        chk("s_rdata", d_rdata, 32'h0);
        chk("s_mreq", {31'h0, mem_req}, 32'h0);
        chk("s_err", {31'h0, d_err}, 32'h0);
        tick();

        // Starvation guard with zero-wait memory
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            tick();
            if (if_gnt || d_gnt) begin
                chk($sformatf("starve%0d", k), {31'h0, if_gnt},
                    (k % 5 == 4) ? 32'h1 : 32'h0);
                k++;
            end
        end
        chk("starve_n", k, 10);
        if_req = 0; d_req = 0;
        repeat (4) tick();
        mem_gnt = 0; mem_rvalid = 0;
        tick();

        // Rvalid on the final WAIT cycle beats the timeout
        d_req = 1; d_we = 0; d_addr = 32'h80;
        tick();
        chk("c_gnt", {31'h0, d_gnt}, 32'h1);
        d_req = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        repeat (63) tick();
        mem_rvalid = 1; mem_rdata = 32'h55;
        tick();
        mem_rvalid = 0;
        chk("c_rv", {31'h0, d_rvalid}, 32'h1);
        chk("c_data", d_rdata, 32'h55);
        chk("c_err", {31'h0, d_err}, 32'h0);
        chk("c_sticky", {31'h0, err_sticky}, 32'h0);
        tick();

        // Read timeout
        d_req = 1; d_we = 0; d_addr = 32'h84;
        tick();
        chk("t_gnt", {31'h0, d_gnt}, 32'h1);
        d_req = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        n = 0;
        while (!d_rvalid && n < 100) begin
            tick();
            n++;
        end
        chk("t_lat", n, 64);
        chk("t_data", d_rdata, 32'hDEADBEEF);
        chk("t_err", {31'h0, d_err}, 32'h1);
        chk("t_sticky", {31'h0, err_sticky}, 32'h1);
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 0;
        chk("t_late", {30'h0, d_rvalid, if_rvalid}, 32'h0);
        chk("t_err_pulse", {31'h0, d_err}, 32'h0);
        chk("t_sticky_hold", {31'h0, err_sticky}, 32'h1);
        tick();

        // Asynchronous reset in WAIT
        if_req = 1; if_addr = 32'h400;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("ar_ctl", ctl(), 32'h0);
        chk("ar_addr", mem_addr, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        chk("ar_gnt", {31'h0, if_gnt}, 32'h1);
        chk("ar_stale", {30'h0, d_rvalid, if_rvalid}, 32'h0);
        chk("ar_addr2", mem_addr, 32'h400);
        if_req = 0; mem_rvalid = 0; mem_gnt = 1;
        tick();
        mem_gnt = 0;
        chk("ar_wait", {31'h0, if_rvalid}, 32'h0);
        mem_rvalid = 1; mem_rdata = 32'h99;
        tick();
        mem_rvalid = 0;
        chk("ar_rv", {31'h0, if_rvalid}, 32'h1);
        chk("ar_data", if_rdata, 32'h99);
        chk("ar_err", {30'h0, d_err, err_sticky}, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
